// File: rtl/p3_execute.sv
// Execute stage of the SIMPLE pipeline: ALU, S/Z/C/V flags, branch resolve/squash, sticky halt.
// Optional I/O port (IN/OUT opcodes) enabled by defining P3_IO_PORT_EN.
module p3_execute #(
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic        clockp3,
    input  logic        reset,
    input  logic        stall,
    input  logic        validin,
    input  logic [15:0] alu1,
    input  logic [15:0] alu2,
    input  logic [3:0]  opcode,
    input  logic        writereg,
    input  logic [1:0]  memwrite,
    input  logic [2:0]  regaddress,
    input  logic [15:0] address,
    input  logic [15:0] storedata,
    input  logic        isbranch,
    input  logic [2:0]  cond,
    input  logic [15:0] pcin,
    input  logic        haltin,
`ifdef P3_IO_PORT_EN
    input  logic [15:0] inport,
    output logic [15:0] outport,
    output logic        outvalid,
`endif
    output logic [15:0] aluresult,
    output logic        writeregout,
    output logic [1:0]  memwriteout,
    output logic [2:0]  regaddressout,
    output logic [15:0] addressout,
    output logic [15:0] storedataout,
    output logic        validout,
    output logic [3:0]  flags,
    output logic        branchtaken,
    output logic [15:0] branchtarget,
    output logic        haltout
);

    typedef enum logic [3:0] {
        OpAdd = 4'd0,  OpSub = 4'd1,  OpAnd = 4'd2,  OpOr  = 4'd3,
        OpXor = 4'd4,  OpCmp = 4'd5,  OpMov = 4'd6,  OpNop7 = 4'd7,
        OpSll = 4'd8,  OpSlr = 4'd9,  OpSrl = 4'd10, OpSra = 4'd11,
        OpIn  = 4'd12, OpOut = 4'd13, OpNop14 = 4'd14, OpHlt = 4'd15
    } op_e;

    localparam logic [1:0] FlushLoad = 2'(FLUSH_DEPTH);

    logic [1:0]  squash_q;
    logic        branchtaken_q;

    logic [15:0] a, b, res;
    logic [3:0]  n;
    logic [16:0] sum, dif, shl, shr, sra;
    logic [15:0] rot;
    logic        c_new, v_new, upd;
    logic [3:0]  flags_new;
    logic        live, cond_true, take;

    always_comb begin
        a   = alu2;
        b   = alu1;
        n   = alu1[3:0];
        sum = {1'b0, a} + {1'b0, b};
        dif = {1'b0, a} - {1'b0, b};
        // Shifts carry a guard bit so the last bit shifted out lands in bit 16 / bit 0.
        shl = {1'b0, a} << n;
        shr = {a, 1'b0} >> n;
        sra = $signed({a, 1'b0}) >>> n;
        rot = (a << n) | (a >> (5'd16 - {1'b0, n}));

        res   = 16'h0000;
        c_new = 1'b0;
        v_new = 1'b0;
        upd   = 1'b0;
        case (op_e'(opcode))
            OpAdd: begin
                res   = sum[15:0];
                c_new = sum[16];
                v_new = (a[15] == b[15]) && (res[15] != a[15]);
                upd   = 1'b1;
            end
            OpSub, OpCmp: begin
                res   = dif[15:0];
                c_new = dif[16];
                v_new = (a[15] != b[15]) && (res[15] != a[15]);
                upd   = 1'b1;
            end
            OpAnd: begin res = a & b; upd = 1'b1; end
            OpOr:  begin res = a | b; upd = 1'b1; end
            OpXor: begin res = a ^ b; upd = 1'b1; end
            OpMov: begin res = b;     upd = 1'b1; end
            OpSll: begin res = shl[15:0]; c_new = shl[16]; upd = 1'b1; end
            OpSlr: begin res = rot; c_new = (n != 4'd0) & rot[0]; upd = 1'b1; end
            OpSrl: begin res = shr[16:1]; c_new = shr[0]; upd = 1'b1; end
            OpSra: begin res = sra[16:1]; c_new = sra[0]; upd = 1'b1; end
`ifdef P3_IO_PORT_EN
            OpIn:  res = inport;
`endif
            default: res = 16'h0000;
        endcase
        flags_new = {res[15], (res == 16'h0000), c_new, v_new};
    end

    // Branch conditions see the flag register before this cycle's update.
    always_comb begin
        case (cond)
            3'd0:    cond_true = flags[2];
            3'd1:    cond_true = flags[3] ^ flags[0];
            3'd2:    cond_true = flags[2] | (flags[3] ^ flags[0]);
            3'd3:    cond_true = ~flags[2];
            3'd4:    cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign live        = validin & (squash_q == 2'd0) & ~haltout;
    assign take        = live & isbranch & cond_true;
    assign branchtaken = branchtaken_q & ~stall;

    always_ff @(posedge clockp3) begin
        if (reset) begin
            aluresult     <= 16'h0000;
            writeregout   <= 1'b0;
            memwriteout   <= 2'b00;
            regaddressout <= 3'b000;
            addressout    <= 16'h0000;
            storedataout  <= 16'h0000;
            validout      <= 1'b0;
            flags         <= 4'b0000;
            branchtaken_q <= 1'b0;
            branchtarget  <= RESET_PC;
            haltout       <= 1'b0;
            squash_q      <= 2'd0;
`ifdef P3_IO_PORT_EN
            outport       <= 16'h0000;
            outvalid      <= 1'b0;
`endif
        end else if (stall) begin
            branchtaken_q <= 1'b0;
        end else begin
            aluresult     <= res;
            writeregout   <= live & writereg & (opcode != OpCmp);
            memwriteout   <= live ? memwrite : 2'b00;
            regaddressout <= regaddress;
            addressout    <= address;
            storedataout  <= storedata;
            validout      <= live;
            branchtaken_q <= take;
            if (take) begin
                branchtarget <= pcin + address;
            end
            if (live & ~isbranch & upd) begin
                flags <= flags_new;
            end
            if (take) begin
                squash_q <= FlushLoad;
            end else if (validin && squash_q != 2'd0) begin
                squash_q <= squash_q - 2'd1;
            end
            if (live & haltin) begin
                haltout <= 1'b1;
            end
`ifdef P3_IO_PORT_EN
            outvalid <= live & ~isbranch & (opcode == OpOut);
            if (live & ~isbranch & (opcode == OpOut)) begin
                outport <= alu1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_p3_execute.sv
// Self-checking bench for p3_execute: scoreboard of expected bundles, one task per scenario.
// Define P3_IO_PORT_EN to also exercise the I/O port.
module tb_p3_execute;

    logic        clockp3 = 1'b0;
    logic        reset, stall, validin;
    logic [15:0] alu1, alu2, address, storedata, pcin;
    logic [3:0]  opcode;
    logic        writereg, isbranch, haltin;
    logic [1:0]  memwrite;
    logic [2:0]  regaddress, cond;
    logic [15:0] aluresult, addressout, storedataout, branchtarget;
    logic        writeregout, validout, branchtaken, haltout;
    logic [1:0]  memwriteout;
    logic [2:0]  regaddressout;
    logic [3:0]  flags;
`ifdef P3_IO_PORT_EN
    logic [15:0] inport, outport;
    logic        outvalid;
`endif

    int errors = 0;
    int checks = 0;

    p3_execute #(.FLUSH_DEPTH(2), .RESET_PC(16'h1234)) dut (
        .clockp3(clockp3), .reset(reset), .stall(stall), .validin(validin),
        .alu1(alu1), .alu2(alu2), .opcode(opcode), .writereg(writereg),
        .memwrite(memwrite), .regaddress(regaddress), .address(address),
        .storedata(storedata), .isbranch(isbranch), .cond(cond), .pcin(pcin),
        .haltin(haltin),
`ifdef P3_IO_PORT_EN
        .inport(inport), .outport(outport), .outvalid(outvalid),
`endif
        .aluresult(aluresult), .writeregout(writeregout), .memwriteout(memwriteout),
        .regaddressout(regaddressout), .addressout(addressout),
        .storedataout(storedataout), .validout(validout), .flags(flags),
        .branchtaken(branchtaken), .branchtarget(branchtarget), .haltout(haltout)
    );

    always #5 clockp3 = ~clockp3;

    typedef struct {
        logic v; logic [3:0] op; logic [15:0] a2, a1; logic wr; logic [1:0] mw;
        logic br; logic [2:0] cnd; logic [15:0] pc, disp; logic stl;
    } stim_t;

    typedef struct {
        logic [15:0] res; logic cres; logic valid, wr; logic [1:0] mw; logic [3:0] fl;
        logic bt, ctgt; logic [15:0] tgt; logic halt;
    } exp_t;

    exp_t sbq[$];

    function automatic stim_t alu(input logic v, input logic [3:0] op, input logic [15:0] a2,
                                  input logic [15:0] a1, input logic wr, input logic [1:0] mw,
                                  input logic stl);
        stim_t s;
        s = '{v: v, op: op, a2: a2, a1: a1, wr: wr, mw: mw, br: 1'b0, cnd: 3'd0,
              pc: 16'h0, disp: 16'h0, stl: stl};
        return s;
    endfunction

    function automatic stim_t brs(input logic [2:0] cnd, input logic [15:0] pc,
                                  input logic [15:0] disp);
        stim_t s;
        s = '{v: 1'b1, op: 4'd7, a2: 16'h0, a1: 16'h0, wr: 1'b0, mw: 2'b00, br: 1'b1,
              cnd: cnd, pc: pc, disp: disp, stl: 1'b0};
        return s;
    endfunction

    function automatic exp_t ex(input logic [15:0] res, input logic cres, input logic valid,
                                input logic wr, input logic [1:0] mw, input logic [3:0] fl,
                                input logic bt, input logic ctgt, input logic [15:0] tgt,
                                input logic halt);
        exp_t e;
        e = '{res: res, cres: cres, valid: valid, wr: wr, mw: mw, fl: fl, bt: bt,
              ctgt: ctgt, tgt: tgt, halt: halt};
        return e;
    endfunction

    task automatic apply(input stim_t s);
        validin    = s.v;
        opcode     = s.op;
        alu2       = s.a2;
        alu1       = s.a1;
        writereg   = s.wr;
        memwrite   = s.mw;
        isbranch   = s.br;
        cond       = s.cnd;
        pcin       = s.pc;
        address    = s.disp;
        stall      = s.stl;
        haltin     = (s.op == 4'd15) && !s.br;
        regaddress = s.a2[2:0] ^ 3'd5;
        storedata  = s.a1 ^ 16'h5A5A;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        apply(alu(1'b1, 4'd0, 16'h1111, 16'h2222, 1'b1, 2'b11, 1'b1));
        repeat (2) @(posedge clockp3);
        #1;
        checks++; if (aluresult !== 16'h0) begin errors++; $display("FAIL reset_aluresult got %h want 0000", aluresult); end
        checks++; if (validout !== 1'b0) begin errors++; $display("FAIL reset_validout got %b want 0", validout); end
        checks++; if (writeregout !== 1'b0 || memwriteout !== 2'b00) begin errors++; $display("FAIL reset_ctrl got wr=%b mw=%b want 0/00", writeregout, memwriteout); end
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", flags); end
        checks++; if (branchtaken !== 1'b0 || branchtarget !== 16'h1234) begin errors++; $display("FAIL reset_branch got bt=%b tgt=%h want 0/1234", branchtaken, branchtarget); end
        checks++; if (haltout !== 1'b0) begin errors++; $display("FAIL reset_halt got %b want 0", haltout); end
        checks++; if (regaddressout !== 3'd0 || addressout !== 16'h0 || storedataout !== 16'h0) begin errors++; $display("FAIL reset_pass got %h %h %h want 0", regaddressout, addressout, storedataout); end
        reset = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_alu;
        stim_t st[$];
        exp_t  xp[$];
        exp_t  e;
        st.push_back(alu(1, 4'd0,  16'h7FFF, 16'h0001, 1, 2'b00, 0)); xp.push_back(ex(16'h8000, 1, 1, 1, 2'b00, 4'b1001, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd0,  16'hFFFF, 16'h0001, 1, 2'b01, 0)); xp.push_back(ex(16'h0000, 1, 1, 1, 2'b01, 4'b0110, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd1,  16'h0003, 16'h0005, 1, 2'b00, 0)); xp.push_back(ex(16'hFFFE, 1, 1, 1, 2'b00, 4'b1010, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd1,  16'h8000, 16'h0001, 1, 2'b00, 0)); xp.push_back(ex(16'h7FFF, 1, 1, 1, 2'b00, 4'b0001, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd2,  16'hF0F0, 16'h0FF0, 1, 2'b00, 0)); xp.push_back(ex(16'h00F0, 1, 1, 1, 2'b00, 4'b0000, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd3,  16'hF000, 16'h000F, 1, 2'b00, 0)); xp.push_back(ex(16'hF00F, 1, 1, 1, 2'b00, 4'b1000, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd4,  16'h1234, 16'h1234, 1, 2'b00, 0)); xp.push_back(ex(16'h0000, 1, 1, 1, 2'b00, 4'b0100, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd6,  16'h5555, 16'h8000, 1, 2'b00, 0)); xp.push_back(ex(16'h8000, 1, 1, 1, 2'b00, 4'b1000, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd8,  16'h8001, 16'h0001, 1, 2'b00, 0)); xp.push_back(ex(16'h0002, 1, 1, 1, 2'b00, 4'b0010, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd8,  16'h1234, 16'h0000, 1, 2'b00, 0)); xp.push_back(ex(16'h1234, 1, 1, 1, 2'b00, 4'b0000, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd9,  16'h9001, 16'h0004, 1, 2'b00, 0)); xp.push_back(ex(16'h0019, 1, 1, 1, 2'b00, 4'b0010, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd10, 16'h8001, 16'h0001, 1, 2'b00, 0)); xp.push_back(ex(16'h4000, 1, 1, 1, 2'b00, 4'b0010, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd11, 16'h8001, 16'h0001, 1, 2'b00, 0)); xp.push_back(ex(16'hC000, 1, 1, 1, 2'b00, 4'b1010, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd7,  16'h0001, 16'h0001, 1, 2'b00, 0)); xp.push_back(ex(16'h0000, 1, 1, 1, 2'b00, 4'b1010, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd12, 16'h00FF, 16'h00FF, 1, 2'b00, 0)); xp.push_back(ex(16'h0000, 1, 1, 1, 2'b00, 4'b1010, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd5,  16'h0005, 16'h0005, 1, 2'b00, 0)); xp.push_back(ex(16'h0000, 1, 1, 0, 2'b00, 4'b0100, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sbq.push_back(xp[i]);
            @(posedge clockp3);
            #1;
            e = sbq.pop_front();
            checks++; if (aluresult !== e.res) begin errors++; $display("FAIL alu[%0d] aluresult got %h want %h", i, aluresult, e.res); end
            checks++; if (flags !== e.fl) begin errors++; $display("FAIL alu[%0d] flags got %b want %b", i, flags, e.fl); end
            checks++; if (validout !== e.valid || writeregout !== e.wr || memwriteout !== e.mw) begin
                errors++; $display("FAIL alu[%0d] ctrl got v=%b wr=%b mw=%b want v=%b wr=%b mw=%b", i, validout, writeregout, memwriteout, e.valid, e.wr, e.mw); end
            checks++; if (storedataout !== (st[i].a1 ^ 16'h5A5A) || regaddressout !== (st[i].a2[2:0] ^ 3'd5)) begin
                errors++; $display("FAIL alu[%0d] passthrough got sd=%h ra=%h", i, storedataout, regaddressout); end
        end
    endtask

    task automatic test_branch;
        stim_t st[$];
        exp_t  xp[$];
        exp_t  e;
        st.push_back(alu(1, 4'd5, 16'h0005, 16'h0005, 1, 2'b00, 0)); xp.push_back(ex(16'h0000, 1, 1, 0, 2'b00, 4'b0100, 0, 0, 0, 0));
        st.push_back(brs(3'd0, 16'h0010, 16'hFFFE));                  xp.push_back(ex(0, 0, 1, 0, 2'b00, 4'b0100, 1, 1, 16'h000E, 0));
        st.push_back(alu(1, 4'd0, 16'h0001, 16'h0001, 1, 2'b11, 0)); xp.push_back(ex(0, 0, 0, 0, 2'b00, 4'b0100, 0, 0, 0, 0));
        st.push_back(alu(0, 4'd0, 16'h0001, 16'h0001, 1, 2'b11, 0)); xp.push_back(ex(0, 0, 0, 0, 2'b00, 4'b0100, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd0, 16'h0001, 16'h0001, 1, 2'b11, 0)); xp.push_back(ex(0, 0, 0, 0, 2'b00, 4'b0100, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd0, 16'h0001, 16'h0002, 1, 2'b11, 0)); xp.push_back(ex(16'h0003, 1, 1, 1, 2'b11, 4'b0000, 0, 0, 0, 0));
        st.push_back(brs(3'd0, 16'h0000, 16'h0000));                  xp.push_back(ex(0, 0, 1, 0, 2'b00, 4'b0000, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd1, 16'h0003, 16'h0005, 1, 2'b00, 0)); xp.push_back(ex(16'hFFFE, 1, 1, 1, 2'b00, 4'b1010, 0, 0, 0, 0));
        st.push_back(brs(3'd1, 16'h0100, 16'h0050));                  xp.push_back(ex(0, 0, 1, 0, 2'b00, 4'b1010, 1, 1, 16'h0150, 0));
        st.push_back(brs(3'd4, 16'h0200, 16'h0000));                  xp.push_back(ex(0, 0, 0, 0, 2'b00, 4'b1010, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd0, 16'h0001, 16'h0001, 1, 2'b00, 0)); xp.push_back(ex(0, 0, 0, 0, 2'b00, 4'b1010, 0, 0, 0, 0));
        st.push_back(brs(3'd4, 16'hFFFF, 16'h0002));                  xp.push_back(ex(0, 0, 1, 0, 2'b00, 4'b1010, 1, 1, 16'h0001, 0));
        st.push_back(alu(1, 4'd0, 16'h0001, 16'h0001, 1, 2'b00, 0)); xp.push_back(ex(0, 0, 0, 0, 2'b00, 4'b1010, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd0, 16'h0001, 16'h0001, 1, 2'b00, 0)); xp.push_back(ex(0, 0, 0, 0, 2'b00, 4'b1010, 0, 0, 0, 0));
        st.push_back(brs(3'd5, 16'h0000, 16'h0000));                  xp.push_back(ex(0, 0, 1, 0, 2'b00, 4'b1010, 0, 0, 0, 0));
        st.push_back(brs(3'd2, 16'h0300, 16'h0004));                  xp.push_back(ex(0, 0, 1, 0, 2'b00, 4'b1010, 1, 1, 16'h0304, 0));
        st.push_back(alu(1, 4'd0, 16'h0001, 16'h0001, 1, 2'b00, 0)); xp.push_back(ex(0, 0, 0, 0, 2'b00, 4'b1010, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd0, 16'h0001, 16'h0001, 1, 2'b00, 0)); xp.push_back(ex(0, 0, 0, 0, 2'b00, 4'b1010, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sbq.push_back(xp[i]);
            @(posedge clockp3);
            #1;
            e = sbq.pop_front();
            checks++; if (validout !== e.valid || writeregout !== e.wr || memwriteout !== e.mw) begin
                errors++; $display("FAIL branch[%0d] ctrl got v=%b wr=%b mw=%b want v=%b wr=%b mw=%b", i, validout, writeregout, memwriteout, e.valid, e.wr, e.mw); end
            checks++; if (branchtaken !== e.bt) begin errors++; $display("FAIL branch[%0d] branchtaken got %b want %b", i, branchtaken, e.bt); end
            checks++; if (flags !== e.fl) begin errors++; $display("FAIL branch[%0d] flags got %b want %b", i, flags, e.fl); end
            if (e.cres) begin
                checks++; if (aluresult !== e.res) begin errors++; $display("FAIL branch[%0d] aluresult got %h want %h", i, aluresult, e.res); end
            end
            if (e.ctgt) begin
                checks++; if (branchtarget !== e.tgt) begin errors++; $display("FAIL branch[%0d] branchtarget got %h want %h", i, branchtarget, e.tgt); end
            end
        end
    endtask

    task automatic test_stall;
        stim_t st[$];
        exp_t  xp[$];
        exp_t  e;
        st.push_back(alu(1, 4'd0, 16'h0010, 16'h0020, 1, 2'b00, 0)); xp.push_back(ex(16'h0030, 1, 1, 1, 2'b00, 4'b0000, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(alu(1, 4'd0, 16'hFFFF, 16'h0001, 1, 2'b00, 1)); xp.push_back(ex(16'h0030, 1, 1, 1, 2'b00, 4'b0000, 0, 0, 0, 0));
        end
        st.push_back(alu(1, 4'd0, 16'hFFFF, 16'h0001, 1, 2'b00, 0)); xp.push_back(ex(16'h0000, 1, 1, 1, 2'b00, 4'b0110, 0, 0, 0, 0));
        st.push_back(brs(3'd4, 16'h0020, 16'h0010));                  xp.push_back(ex(0, 0, 1, 0, 2'b00, 4'b0110, 1, 1, 16'h0030, 0));
        for (int k = 0; k < 3; k++) begin
            st.push_back(alu(1, 4'd0, 16'h0001, 16'h0001, 1, 2'b00, 1)); xp.push_back(ex(0, 0, 1, 0, 2'b00, 4'b0110, 0, 1, 16'h0030, 0));
        end
        st.push_back(alu(1, 4'd0, 16'h0001, 16'h0001, 1, 2'b00, 0)); xp.push_back(ex(0, 0, 0, 0, 2'b00, 4'b0110, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd0, 16'h0001, 16'h0001, 1, 2'b00, 0)); xp.push_back(ex(0, 0, 0, 0, 2'b00, 4'b0110, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd0, 16'h0002, 16'h0002, 1, 2'b00, 0)); xp.push_back(ex(16'h0004, 1, 1, 1, 2'b00, 4'b0000, 0, 0, 0, 0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sbq.push_back(xp[i]);
            @(posedge clockp3);
            #1;
            e = sbq.pop_front();
            checks++; if (validout !== e.valid || writeregout !== e.wr) begin
                errors++; $display("FAIL stall[%0d] ctrl got v=%b wr=%b want v=%b wr=%b", i, validout, writeregout, e.valid, e.wr); end
            checks++; if (flags !== e.fl) begin errors++; $display("FAIL stall[%0d] flags got %b want %b", i, flags, e.fl); end
            checks++; if (branchtaken !== e.bt) begin errors++; $display("FAIL stall[%0d] branchtaken got %b want %b", i, branchtaken, e.bt); end
            if (e.cres) begin
                checks++; if (aluresult !== e.res) begin errors++; $display("FAIL stall[%0d] aluresult got %h want %h", i, aluresult, e.res); end
            end
            if (e.ctgt) begin
                checks++; if (branchtarget !== e.tgt) begin errors++; $display("FAIL stall[%0d] branchtarget got %h want %h", i, branchtarget, e.tgt); end
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_halt;
        stim_t st[$];
        exp_t  xp[$];
        exp_t  e;
        st.push_back(alu(1, 4'd1,  16'h0003, 16'h0005, 1, 2'b00, 0)); xp.push_back(ex(16'hFFFE, 1, 1, 1, 2'b00, 4'b1010, 0, 0, 0, 0));
        st.push_back(alu(1, 4'd15, 16'h0000, 16'h0000, 0, 2'b00, 0)); xp.push_back(ex(16'h0000, 1, 1, 0, 2'b00, 4'b1010, 0, 0, 0, 1));
        st.push_back(alu(1, 4'd0,  16'hFFFF, 16'h0001, 1, 2'b10, 0)); xp.push_back(ex(0, 0, 0, 0, 2'b00, 4'b1010, 0, 0, 0, 1));
        st.push_back(brs(3'd4, 16'h0000, 16'h0005));                   xp.push_back(ex(0, 0, 0, 0, 2'b00, 4'b1010, 0, 0, 0, 1));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            sbq.push_back(xp[i]);
            @(posedge clockp3);
            #1;
            e = sbq.pop_front();
            checks++; if (haltout !== e.halt) begin errors++; $display("FAIL halt[%0d] haltout got %b want %b", i, haltout, e.halt); end
            checks++; if (validout !== e.valid || writeregout !== e.wr || memwriteout !== e.mw) begin
                errors++; $display("FAIL halt[%0d] ctrl got v=%b wr=%b mw=%b want v=%b wr=%b mw=%b", i, validout, writeregout, memwriteout, e.valid, e.wr, e.mw); end
            checks++; if (flags !== e.fl || branchtaken !== e.bt) begin
                errors++; $display("FAIL halt[%0d] flags/bt got %b/%b want %b/%b", i, flags, branchtaken, e.fl, e.bt); end
        end
        // Reset must beat a simultaneous stall and taken branch.
        haltout_reset_check();
    endtask

    task automatic haltout_reset_check;
        apply(brs(3'd4, 16'h0000, 16'h0005));
        stall = 1'b1;
        reset = 1'b1;
        @(posedge clockp3);
        #1;
        checks++; if (haltout !== 1'b0 || flags !== 4'b0000) begin errors++; $display("FAIL halt_reset got halt=%b flags=%b want 0/0000", haltout, flags); end
        checks++; if (branchtaken !== 1'b0 || branchtarget !== 16'h1234 || validout !== 1'b0) begin
            errors++; $display("FAIL halt_reset_branch got bt=%b tgt=%h v=%b want 0/1234/0", branchtaken, branchtarget, validout); end
        reset = 1'b0;
        apply(alu(1, 4'd0, 16'h0001, 16'h0001, 1, 2'b00, 0));
        @(posedge clockp3);
        #1;
        checks++; if (validout !== 1'b1 || aluresult !== 16'h0002) begin
            errors++; $display("FAIL post_reset_add got v=%b r=%h want 1/0002", validout, aluresult); end
    endtask

`ifdef P3_IO_PORT_EN
    task automatic test_io;
        apply(alu(1, 4'd13, 16'h0000, 16'h00AB, 0, 2'b00, 0));
        @(posedge clockp3);
        #1;
        checks++; if (outport !== 16'h00AB || outvalid !== 1'b1) begin errors++; $display("FAIL io_out got %h/%b want 00AB/1", outport, outvalid); end
        inport = 16'hBEEF;
        apply(alu(1, 4'd12, 16'h0000, 16'h0000, 1, 2'b00, 0));
        @(posedge clockp3);
        #1;
        checks++; if (outvalid !== 1'b0 || outport !== 16'h00AB) begin errors++; $display("FAIL io_pulse got %h/%b want 00AB/0", outport, outvalid); end
        checks++; if (aluresult !== 16'hBEEF) begin errors++; $display("FAIL io_in got %h want BEEF", aluresult); end
        inport = 16'h0000;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef P3_IO_PORT_EN
        inport = 16'h0000;
`endif
        stall = 1'b0;
        test_reset();
        test_alu();
        test_branch();
        test_stall();
        test_halt();
`ifdef P3_IO_PORT_EN
        test_io();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
